// File: rtl/ptw_monitor_mc.sv
// Purpose : per-channel PTW walk monitor; tracks outstanding walks, latency, hit/miss/AE counts, sticky errors.
// Latency : all outputs are registered; counters and errors reflect an event one clock after it is sampled.
// Backpress: passive observer; req_ready/req_valid are only sampled, never driven.
// Ports   : clk, rst_n (async active-low), stats_clr; req_valid/req_ready/req_addr per channel;
//           resp_valid/resp_ae/resp_pte_v/resp_ppn/resp_flags per channel; hit_cnt/miss_cnt/ae_cnt,
//           max_lat, busy, err_timeout/err_spurious/err_overlap per channel.
// Option  : define PTW_MON_LOG_EN to print one `logI line per response and per error event.
`ifdef PTW_MON_LOG_EN
`ifndef logI
`define logI(msg) $display("%s", msg)
`endif
`endif

module ptw_monitor_mc #(
  parameter int NUM_REQ     = 2,
  parameter int VPN_W       = 27,
  parameter int PPN_W       = 54,
  parameter int CNT_W       = 32,
  parameter int LAT_W       = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stats_clr,
  input  logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*VPN_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0]       resp_valid,
  input  logic [NUM_REQ-1:0]       resp_ae,
  input  logic [NUM_REQ-1:0]       resp_pte_v,
  input  logic [NUM_REQ*PPN_W-1:0] resp_ppn,
  input  logic [NUM_REQ*7-1:0]     resp_flags,
  output logic [NUM_REQ*CNT_W-1:0] hit_cnt,
  output logic [NUM_REQ*CNT_W-1:0] miss_cnt,
  output logic [NUM_REQ*CNT_W-1:0] ae_cnt,
  output logic [NUM_REQ*LAT_W-1:0] max_lat,
  output logic [NUM_REQ-1:0]       busy,
  output logic [NUM_REQ-1:0]       err_timeout,
  output logic [NUM_REQ-1:0]       err_spurious,
  output logic [NUM_REQ-1:0]       err_overlap
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_TMO  = 2'd2;

  // Timeout threshold at latency width; values beyond LAT_W wrap.
  localparam logic [LAT_W-1:0] L_TMO = LAT_W'(TIMEOUT_CYC);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_ch
    logic [1:0]       r_state;
    logic [LAT_W-1:0] r_lat;
    logic [VPN_W-1:0] r_vpn;
    logic [CNT_W-1:0] r_hit, r_miss, r_ae;
    logic [LAT_W-1:0] r_max;
    logic             r_tmo, r_spur, r_ovl;

    logic             w_fire, w_rsp, w_active, w_done, w_to;
    logic [LAT_W-1:0] w_lat_inc;

    assign w_fire    = req_valid[i] & req_ready[i];
    assign w_rsp     = resp_valid[i];
    assign w_active  = (r_state != S_IDLE);
    assign w_done    = w_active & w_rsp;
    // r_lat holds k-1 on the edge k cycles after fire, so the
    // saturated increment is both the completion latency and the
    // value compared against the timeout threshold.
    assign w_lat_inc = (&r_lat) ? r_lat : r_lat + 1'b1;
    assign w_to      = (r_state == S_WAIT) & ~w_rsp & ~w_fire & (w_lat_inc == L_TMO);

    // Walk tracking; stats_clr deliberately has no effect here.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= S_IDLE;
        r_lat   <= '0;
        r_vpn   <= '0;
      end else if (w_fire) begin
        // New walk always opens in WAIT, whether from IDLE, WAIT or TMO.
        r_state <= S_WAIT;
        r_lat   <= '0;
        r_vpn   <= req_addr[i*VPN_W +: VPN_W];
      end else if (w_done) begin
        r_state <= S_IDLE;
      end else begin
        if (w_active) r_lat <= w_lat_inc;
        if (w_to)     r_state <= S_TMO;
      end
    end

    // Statistics and sticky errors; a same-cycle clear drops the event.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_hit  <= '0;
        r_miss <= '0;
        r_ae   <= '0;
        r_max  <= '0;
        r_tmo  <= 1'b0;
        r_spur <= 1'b0;
        r_ovl  <= 1'b0;
      end else if (stats_clr) begin
        r_hit  <= '0;
        r_miss <= '0;
        r_ae   <= '0;
        r_max  <= '0;
        r_tmo  <= 1'b0;
        r_spur <= 1'b0;
        r_ovl  <= 1'b0;
      end else begin
        if (w_done) begin
          if (resp_ae[i]) begin
            if (~&r_ae) r_ae <= r_ae + 1'b1;
          end else if (!resp_pte_v[i]) begin
            if (~&r_miss) r_miss <= r_miss + 1'b1;
          end else begin
            if (~&r_hit) r_hit <= r_hit + 1'b1;
          end
          if (w_lat_inc > r_max) r_max <= w_lat_inc;
        end
        if (w_to)                         r_tmo  <= 1'b1;
        if (w_rsp & ~w_active)            r_spur <= 1'b1;
        if (w_fire & w_active & ~w_rsp)   r_ovl  <= 1'b1;
      end
    end

    assign hit_cnt [i*CNT_W +: CNT_W] = r_hit;
    assign miss_cnt[i*CNT_W +: CNT_W] = r_miss;
    assign ae_cnt  [i*CNT_W +: CNT_W] = r_ae;
    assign max_lat [i*LAT_W +: LAT_W] = r_max;
    assign busy[i]         = w_active;
    assign err_timeout[i]  = r_tmo;
    assign err_spurious[i] = r_spur;
    assign err_overlap[i]  = r_ovl;

`ifdef PTW_MON_LOG_EN
    always @(posedge clk) begin
      if (rst_n) begin
        if (w_done) begin
          if (resp_ae[i])
            `logI($sformatf("-->PTW%0d access fault: VPN=0x%0h", i, r_vpn));
          else if (!resp_pte_v[i])
            `logI($sformatf("-->PTW%0d miss: VPN=0x%0h", i, r_vpn));
          else
            `logI($sformatf("-->PTW%0d hit: VPN=0x%0h PPN=0x%0h d/a/g/u/x/w/r=%07b lat=%0d",
                            i, r_vpn, resp_ppn[i*PPN_W +: PPN_W], resp_flags[i*7 +: 7], w_lat_inc));
        end
        if (w_to)
          `logI($sformatf("-->PTW%0d timeout: VPN=0x%0h", i, r_vpn));
        if (w_rsp & ~w_active)
          `logI($sformatf("-->PTW%0d spurious response", i));
        if (w_fire & w_active & ~w_rsp)
          `logI($sformatf("-->PTW%0d overlap: old VPN=0x%0h new VPN=0x%0h", i, r_vpn,
                          req_addr[i*VPN_W +: VPN_W]));
      end
    end
`else
    // Captured VPN and response payload only feed the log path.
    logic w_unused_log;
    assign w_unused_log = ^{r_vpn, resp_ppn[i*PPN_W +: PPN_W], resp_flags[i*7 +: 7]};
`endif
  end

endmodule

// File: tb/tb_ptw_monitor_mc.sv
module tb_ptw_monitor_mc;
  localparam int N   = 2;
  localparam int VW  = 27;
  localparam int PW  = 54;
  localparam int CW  = 4;
  localparam int LW  = 16;
  localparam int TO  = 8;
  localparam int CMAX = (1 << CW) - 1;
  localparam int LMAX = (1 << LW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stats_clr;
  logic [N-1:0] req_valid, req_ready, resp_valid, resp_ae, resp_pte_v;
  logic [N*VW-1:0] req_addr;
  logic [N*PW-1:0] resp_ppn;
  logic [N*7-1:0]  resp_flags;
  logic [N*CW-1:0] hit_cnt, miss_cnt, ae_cnt;
  logic [N*LW-1:0] max_lat;
  logic [N-1:0] busy, err_timeout, err_spurious, err_overlap;

  ptw_monitor_mc #(.NUM_REQ(N), .VPN_W(VW), .PPN_W(PW), .CNT_W(CW), .LAT_W(LW),
                   .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .stats_clr(stats_clr),
    .req_ready(req_ready), .req_valid(req_valid), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ae(resp_ae), .resp_pte_v(resp_pte_v),
    .resp_ppn(resp_ppn), .resp_flags(resp_flags),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .ae_cnt(ae_cnt), .max_lat(max_lat),
    .busy(busy), .err_timeout(err_timeout), .err_spurious(err_spurious),
    .err_overlap(err_overlap));

  always #5 clk = ~clk;

  // Reference model: a walk is "open since edge t0"; latency is elapsed edges.
  int m_hit[N], m_miss[N], m_ae[N], m_max[N], m_t0[N];
  bit m_busy[N], m_tmo[N], m_spur[N], m_ovl[N];
  int cyc;
  int n_chk, n_bad;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_hit[c] = 0; m_miss[c] = 0; m_ae[c] = 0; m_max[c] = 0; m_t0[c] = 0;
      m_busy[c] = 0; m_tmo[c] = 0; m_spur[c] = 0; m_ovl[c] = 0;
    end
  endtask

  task automatic model_edge();
    for (int c = 0; c < N; c++) begin
      bit fire, rsp;
      int el, lat;
      fire = req_valid[c] && req_ready[c];
      rsp  = resp_valid[c];
      el   = cyc - m_t0[c];
      if (stats_clr) begin
        m_hit[c] = 0; m_miss[c] = 0; m_ae[c] = 0; m_max[c] = 0;
        m_tmo[c] = 0; m_spur[c] = 0; m_ovl[c] = 0;
      end else begin
        if (m_busy[c] && rsp) begin
          lat = (el > LMAX) ? LMAX : el;
          if (resp_ae[c])          begin if (m_ae[c]   < CMAX) m_ae[c]++;   end
          else if (!resp_pte_v[c]) begin if (m_miss[c] < CMAX) m_miss[c]++; end
          else                     begin if (m_hit[c]  < CMAX) m_hit[c]++;  end
          if (lat > m_max[c]) m_max[c] = lat;
        end
        if (rsp && !m_busy[c])                   m_spur[c] = 1;
        if (fire && m_busy[c] && !rsp)           m_ovl[c]  = 1;
        if (m_busy[c] && !rsp && !fire && el == TO) m_tmo[c] = 1;
      end
      if (fire) begin m_busy[c] = 1; m_t0[c] = cyc; end
      else if (rsp) m_busy[c] = 0;
    end
  endtask

  task automatic compare_all();
    for (int c = 0; c < N; c++) begin
      check_val($sformatf("hit%0d", c),  64'(hit_cnt[c*CW +: CW]),  64'(m_hit[c]));
      check_val($sformatf("miss%0d", c), 64'(miss_cnt[c*CW +: CW]), 64'(m_miss[c]));
      check_val($sformatf("ae%0d", c),   64'(ae_cnt[c*CW +: CW]),   64'(m_ae[c]));
      check_val($sformatf("maxlat%0d", c), 64'(max_lat[c*LW +: LW]), 64'(m_max[c]));
      check_val($sformatf("busy%0d", c), 64'(busy[c]),         64'(m_busy[c]));
      check_val($sformatf("tmo%0d", c),  64'(err_timeout[c]),  64'(m_tmo[c]));
      check_val($sformatf("spur%0d", c), 64'(err_spurious[c]), 64'(m_spur[c]));
      check_val($sformatf("ovl%0d", c),  64'(err_overlap[c]),  64'(m_ovl[c]));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_cnt"}, 64'({hit_cnt, miss_cnt, ae_cnt} != 0), 64'(0));
    check_val({tag, "_lat"}, 64'(max_lat), 64'(0));
    check_val({tag, "_flags"}, 64'({busy, err_timeout, err_spurious, err_overlap}), 64'(0));
  endtask

  task automatic clear_in();
    stats_clr = 0; req_valid = '0; req_ready = '0; req_addr = '0;
    resp_valid = '0; resp_ae = '0; resp_pte_v = '0; resp_ppn = '0; resp_flags = '0;
  endtask

  task automatic fire(input int c, input logic [VW-1:0] vpn);
    req_valid[c] = 1'b1; req_ready[c] = 1'b1; req_addr[c*VW +: VW] = vpn;
  endtask

  task automatic resp(input int c, input logic ae, input logic pv, input logic [PW-1:0] ppn);
    resp_valid[c] = 1'b1; resp_ae[c] = ae; resp_pte_v[c] = pv;
    resp_ppn[c*PW +: PW] = ppn; resp_flags[c*7 +: 7] = 7'b1100011;
  endtask

  // Inputs are set at posedge+1; outputs are sampled at the next posedge+1.
  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic clr_step();
    clear_in(); stats_clr = 1; step(); clear_in();
  endtask

  initial begin
    n_chk = 0; n_bad = 0; cyc = 0;
    clear_in();
    model_reset();
    #1;
    check_all_zero("reset0");
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // Single hit on ch0, latency 5.
    fire(0, 27'h0001234); step();
    check_val("r30_busy", 64'(busy[0]), 1);
    clear_in();
    repeat (4) begin step(); check_val("r30_busy", 64'(busy[0]), 1); end
    resp(0, 0, 1, 54'h00ABC); step(); clear_in();
    check_val("r30_hit", 64'(hit_cnt[0 +: CW]), 1);
    check_val("r30_lat", 64'(max_lat[0 +: LW]), 5);
    check_val("r30_idle", 64'(busy[0]), 0);

    // Ch1 miss then AE; ch0 untouched.
    fire(1, 27'h55); step(); clear_in(); step();
    resp(1, 0, 0, '0); step(); clear_in();
    fire(1, 27'h66); step(); clear_in();
    resp(1, 1, 1, '0); step(); clear_in();
    check_val("r31_miss1", 64'(miss_cnt[CW +: CW]), 1);
    check_val("r31_ae1",   64'(ae_cnt[CW +: CW]), 1);
    check_val("r31_hit1",  64'(hit_cnt[CW +: CW]), 0);
    check_val("r31_hit0",  64'(hit_cnt[0 +: CW]), 1);

    // Timeout at 8, late hit at 12.
    clr_step();
    fire(0, 27'h777); step(); clear_in();
    repeat (7) step();
    check_val("r32_notmo", 64'(err_timeout[0]), 0);
    step();
    check_val("r32_tmo", 64'(err_timeout[0]), 1);
    check_val("r32_busy", 64'(busy[0]), 1);
    repeat (3) step();
    resp(0, 0, 1, 54'h1); step(); clear_in();
    check_val("r32_hit", 64'(hit_cnt[0 +: CW]), 1);
    check_val("r32_lat", 64'(max_lat[0 +: LW]), 12);
    check_val("r32_busy0", 64'(busy[0]), 0);

    // Spurious, overlap, and clean back-to-back completion.
    clr_step();
    resp(0, 0, 1, '0); step(); clear_in();
    check_val("r33_spur", 64'(err_spurious[0]), 1);
    check_val("r33_hit0", 64'(hit_cnt[0 +: CW]), 0);
    fire(0, 27'h10); step(); clear_in(); step();
    fire(0, 27'h11); step(); clear_in();
    check_val("r33_ovl", 64'(err_overlap[0]), 1);
    resp(0, 0, 1, '0); step();
    clr_step();
    fire(0, 27'h20); step(); clear_in(); step();
    resp(0, 0, 1, '0); fire(0, 27'h21); step(); clear_in();
    check_val("r33_b2b_err", 64'({err_overlap[0], err_spurious[0], err_timeout[0]}), 0);
    check_val("r33_b2b_busy", 64'(busy[0]), 1);
    check_val("r33_b2b_hit", 64'(hit_cnt[0 +: CW]), 1);
    resp(0, 0, 1, '0); step(); clear_in();

    // Async reset mid-walk with hit_cnt=3.
    clr_step();
    repeat (3) begin fire(0, 27'h30); step(); clear_in(); resp(0, 0, 1, '0); step(); clear_in(); end
    check_val("r34_hit3", 64'(hit_cnt[0 +: CW]), 3);
    fire(0, 27'h31); step(); clear_in(); step();
    rst_n = 0;
    #1;
    check_all_zero("r34_rst");
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    resp(0, 0, 1, '0); step(); clear_in();
    check_val("r34_spur", 64'(err_spurious[0]), 1);

    // Saturation, then clear wins over a same-cycle response.
    clr_step();
    repeat (17) begin fire(0, 27'h40); step(); clear_in(); resp(0, 0, 1, '0); step(); clear_in(); end
    check_val("r35_sat", 64'(hit_cnt[0 +: CW]), 15);
    resp(1, 0, 1, '0); step(); clear_in();
    fire(0, 27'h41); step(); clear_in();
    resp(0, 0, 1, '0); stats_clr = 1; step(); clear_in();
    check_val("r35_clr_hit", 64'(hit_cnt[0 +: CW]), 0);
    check_val("r35_clr_lat", 64'(max_lat[0 +: LW]), 0);
    check_val("r35_clr_spur", 64'(err_spurious[1]), 0);
    check_val("r35_clr_busy", 64'(busy[0]), 0);

    // Randomized traffic against the model.
    for (int t = 0; t < 3000; t++) begin
      clear_in();
      stats_clr = ($urandom_range(0, 99) == 0);
      for (int c = 0; c < N; c++) begin
        req_valid[c]  = ($urandom_range(0, 99) < 25);
        req_ready[c]  = ($urandom_range(0, 99) < 70);
        req_addr[c*VW +: VW] = VW'($urandom);
        resp_valid[c] = ($urandom_range(0, 99) < 15);
        resp_ae[c]    = ($urandom_range(0, 99) < 20);
        resp_pte_v[c] = ($urandom_range(0, 99) < 60);
        resp_ppn[c*PW +: PW] = {22'($urandom), $urandom};
        resp_flags[c*7 +: 7] = 7'($urandom);
      end
      step();
    end
    clear_in();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
